// File: rtl/intr_pkg.sv
// intr_pkg
// Shared types and default configuration for the interrupt responder
// (intr_resp_ctrl) and its priority encoder.
//   state_t  : responder sequencing states (IDLE / TAKE / SERVE)
//   ctx_t    : saved interrupt context {cause, epc}, used by the nesting stack
//   *_DEF    : default values for the top-level parameters
package intr_pkg;

    localparam int          NSRC_DEF      = 6;
    localparam int          PC_W_DEF      = 32;
    localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_1000;
    localparam int          VEC_SHIFT_DEF = 4;

    // Width of the cause field; wide enough for up to eight sources.
    localparam int          CAUSE_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAKE  = 2'd1,
        SERVE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CAUSE_W-1:0]  cause;
        logic [PC_W_DEF-1:0] epc;
    } ctx_t;

endpackage

// File: rtl/intr_resp_ctrl_if.sv
// intr_resp_ctrl_if
// Bundle between the core (fetch / retire logic plus the peripheral request
// lines) and the interrupt responder.
//   master : core side, drives requests and retire information
//   slave  : responder side, drives the take pulse, vector and context
// Signals:
//   irq_in      raw level request lines, bit 0 is the highest priority
//   ie          global interrupt enable
//   instr_done  an instruction retires at this edge
//   pc_next     next sequential PC of the retiring instruction
//   uret        the retiring instruction is uret
//   intr_take   one-cycle pulse, fetch loads handler_pc
//   handler_pc  vector of the source being taken
//   uepc        saved return address
//   ack         one-hot clear pulse to the serviced source
//   in_service  a handler is running
//   cause       index of the serviced source
interface intr_resp_ctrl_if
    import intr_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int PC_W = PC_W_DEF
);

    logic [NSRC-1:0]    irq_in;
    logic               ie;
    logic               instr_done;
    logic [PC_W-1:0]    pc_next;
    logic               uret;

    logic               intr_take;
    logic [PC_W-1:0]    handler_pc;
    logic [PC_W-1:0]    uepc;
    logic [NSRC-1:0]    ack;
    logic               in_service;
    logic [CAUSE_W-1:0] cause;

    modport master (
        output irq_in, ie, instr_done, pc_next, uret,
        input  intr_take, handler_pc, uepc, ack, in_service, cause
    );

    modport slave (
        input  irq_in, ie, instr_done, pc_next, uret,
        output intr_take, handler_pc, uepc, ack, in_service, cause
    );

endinterface

// File: rtl/intr_prio_enc.sv
// intr_prio_enc
// Lowest-index-first priority encoder.
//   req_i : request vector, bit 0 wins
//   sel_o : index of the lowest set bit (0 when nothing is set)
//   any_o : at least one bit of req_i is set
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int NSRC = NSRC_DEF
) (
    input  logic [NSRC-1:0]    req_i,
    output logic [CAUSE_W-1:0] sel_o,
    output logic               any_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        sel_o = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                sel_o = CAUSE_W'(i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/intr_resp_ctrl.sv
// intr_resp_ctrl
// CPU-side interrupt responder. Latches rising edges of the request lines,
// picks the lowest-index pending source, and at an instruction boundary saves
// the return PC, redirects fetch to the source's vector and acknowledges it.
// uret returns the responder to the non-serving state.
// Ports:
//   CLK  system clock, all state on the rising edge
//   RST  synchronous active-high reset
//   bus  intr_resp_ctrl_if slave modport (requests, retire info, outputs)
// Build option:
//   NESTED_INTR_EN  when defined, a strictly higher-priority source preempts a
//                   running handler; the interrupted {cause, uepc} is pushed
//                   on an internal stack of depth NSRC and restored by uret.
module intr_resp_ctrl
    import intr_pkg::*;
#(
    parameter int              NSRC      = NSRC_DEF,
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(VEC_BASE_DEF),
    parameter int              VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    intr_resp_ctrl_if.slave bus
);

    state_t             state_q, state_d;
    logic [NSRC-1:0]    irq_d_q;
    logic [NSRC-1:0]    pend_q, pend_d;
    logic [PC_W-1:0]    uepc_q, uepc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [NSRC-1:0]    ack_vec;
    logic [CAUSE_W-1:0] sel;
    logic               any;

    intr_prio_enc #(.NSRC(NSRC)) u_prio (
        .req_i (pend_q),
        .sel_o (sel),
        .any_o (any)
    );

`ifdef NESTED_INTR_EN
    localparam int SP_W = $clog2(NSRC + 1);

    logic [NSRC-1:0]    higher_mask;
    logic [CAUSE_W-1:0] pre_sel;
    logic               pre_any;
    logic [SP_W-1:0]    sp_q;
    logic [SP_W-1:0]    sp_top;
    ctx_t               stack_q [NSRC];
    ctx_t               top_ctx;
    logic               push, pop;

    // Only sources with an index below the one being served may preempt, so
    // the same encoder is reused on the pending set masked to those bits.
    assign higher_mask = (NSRC'(1) << cause_q) - NSRC'(1);
    assign sp_top      = sp_q - SP_W'(1);
    assign top_ctx     = stack_q[sp_top];

    intr_prio_enc #(.NSRC(NSRC)) u_prio_nest (
        .req_i (pend_q & higher_mask),
        .sel_o (pre_sel),
        .any_o (pre_any)
    );

    // Context stack. Priority strictly rises with every push, so depth NSRC
    // can never overflow. Reset empties the stack; stale entries are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sp_q <= '0;
        end else if (push) begin
            stack_q[sp_q] <= ctx_t'{cause: cause_q, epc: PC_W_DEF'(uepc_q)};
            sp_q          <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_top;
        end
    end
`endif

    // Edge capture of the request lines. A held level never re-arms pend, and
    // a new rising edge in the same cycle as the ack keeps the bit set.
    always_comb begin
        pend_d = (pend_q & ~ack_vec) | (bus.irq_in & ~irq_d_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_d_q <= '0;
            pend_q  <= '0;
        end else begin
            irq_d_q <= bus.irq_in;
            pend_q  <= pend_d;
        end
    end

    // State register together with the saved context it belongs to; reset
    // throws away any context of a handler that was running.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            uepc_q  <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            uepc_q  <= uepc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic. A take only happens at a retire edge, and the return
    // address is that instruction's sequential successor. A uret and a
    // preemption can never share an edge: the uret wins and any preemption
    // waits for the next retire.
    always_comb begin
        state_d = state_q;
        uepc_d  = uepc_q;
        cause_d = cause_q;
`ifdef NESTED_INTR_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.ie && any && bus.instr_done) begin
                    state_d = TAKE;
                    uepc_d  = bus.pc_next;
                    cause_d = sel;
                end
            end
            TAKE: begin
                state_d = SERVE;
            end
            SERVE: begin
`ifdef NESTED_INTR_EN
                if (bus.instr_done && bus.uret) begin
                    if (sp_q != '0) begin
                        pop     = 1'b1;
                        cause_d = top_ctx.cause;
                        uepc_d  = PC_W'(top_ctx.epc);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.instr_done && pre_any) begin
                    push    = 1'b1;
                    state_d = TAKE;
                    uepc_d  = bus.pc_next;
                    cause_d = pre_sel;
                end
`else
                if (bus.instr_done && bus.uret) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state and the saved context only, so the
    // take pulse, ack and vector all line up in the single TAKE cycle.
    always_comb begin
        ack_vec        = (state_q == TAKE) ? (NSRC'(1) << cause_q) : '0;
        bus.intr_take  = (state_q == TAKE);
        bus.ack        = ack_vec;
        bus.in_service = (state_q != IDLE);
        bus.handler_pc = VEC_BASE + (PC_W'(cause_q) << VEC_SHIFT);
        bus.uepc       = uepc_q;
        bus.cause      = cause_q;
    end

endmodule

// File: tb/tb_intr_resp_ctrl.sv
// tb_intr_resp_ctrl
// Self-checking bench for intr_resp_ctrl. Directed scenarios check fixed
// values; a randomized phase compares every cycle against a behavioural model
// kept in the bench (pending set, serving flag, saved context).
module tb_intr_resp_ctrl;

    localparam int NS = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;

    logic [NS-1:0] mPend, mPrev;
    logic          mTake, mServing;
    int            mCause;
    logic [31:0]   mEpc;
`ifdef NESTED_INTR_EN
    int            stkCause[$];
    logic [31:0]   stkEpc[$];
`endif

    intr_resp_ctrl_if #(.NSRC(NS), .PC_W(32)) bus ();

    intr_resp_ctrl #(
        .NSRC      (NS),
        .PC_W      (32),
        .VEC_BASE  (32'h0000_1000),
        .VEC_SHIFT (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic int lowestSet(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Model of one clock edge: decisions use the pending set as it stood
    // before the edge; new rising edges land after the ack is applied.
    task automatic modelEdge();
        logic [NS-1:0] ackNow;
        logic [NS-1:0] rise;
        int            lo;
        if (RST) begin
            mPend = '0; mPrev = '0; mTake = 1'b0; mServing = 1'b0;
            mCause = 0; mEpc = '0;
`ifdef NESTED_INTR_EN
            stkCause.delete(); stkEpc.delete();
`endif
            return;
        end
        ackNow = mTake ? NS'(1 << mCause) : '0;
        rise   = bus.irq_in & ~mPrev;
        lo     = lowestSet(mPend);
        if (mTake) begin
            mTake = 1'b0;
            mServing = 1'b1;
        end else if (!mServing) begin
            if (bus.ie && lo >= 0 && bus.instr_done) begin
                mTake = 1'b1; mEpc = bus.pc_next; mCause = lo;
            end
        end else if (bus.instr_done && bus.uret) begin
`ifdef NESTED_INTR_EN
            if (stkCause.size() > 0) begin
                mCause = stkCause.pop_back();
                mEpc   = stkEpc.pop_back();
            end else begin
                mServing = 1'b0;
            end
`else
            mServing = 1'b0;
`endif
        end
`ifdef NESTED_INTR_EN
        else if (bus.instr_done && lo >= 0 && lo < mCause) begin
            stkCause.push_back(mCause);
            stkEpc.push_back(mEpc);
            mTake = 1'b1; mEpc = bus.pc_next; mCause = lo;
        end
`endif
        mPend = (mPend & ~ackNow) | rise;
        mPrev = bus.irq_in;
    endtask

    // Drive one cycle of inputs at the falling edge, let the DUT and the model
    // see the rising edge, and return at the next falling edge for sampling.
    task automatic applyStimulus(input logic [NS-1:0] irq, input logic ie,
                                 input logic done, input logic [31:0] pc,
                                 input logic ret);
        bus.irq_in     = irq;
        bus.ie         = ie;
        bus.instr_done = done;
        bus.pc_next    = pc;
        bus.uret       = ret;
        @(posedge CLK);
        modelEdge();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b0) $display("[TB] FAIL reset.intr_take got %0h want 0", bus.intr_take); else passCount++;
        checkCount++; if (bus.ack !== 6'h00) $display("[TB] FAIL reset.ack got %0h want 0", bus.ack); else passCount++;
        checkCount++; if (bus.in_service !== 1'b0) $display("[TB] FAIL reset.in_service got %0h want 0", bus.in_service); else passCount++;
        checkCount++; if (bus.uepc !== 32'h0) $display("[TB] FAIL reset.uepc got %0h want 0", bus.uepc); else passCount++;
        checkCount++; if (bus.cause !== 3'd0) $display("[TB] FAIL reset.cause got %0h want 0", bus.cause); else passCount++;
        checkCount++; if (bus.handler_pc !== 32'h1000) $display("[TB] FAIL reset.handler_pc got %0h want 1000", bus.handler_pc); else passCount++;
        RST = 1'b0;
    endtask

    task automatic test_single();
        applyStimulus(6'b000100, 1'b1, 1'b1, 32'h200, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b0) $display("[TB] FAIL single.early_take got %0h want 0", bus.intr_take); else passCount++;
        applyStimulus(6'b000100, 1'b1, 1'b1, 32'h200, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1) $display("[TB] FAIL single.take got %0h want 1", bus.intr_take); else passCount++;
        checkCount++; if (bus.cause !== 3'd2) $display("[TB] FAIL single.cause got %0h want 2", bus.cause); else passCount++;
        checkCount++; if (bus.handler_pc !== 32'h1020) $display("[TB] FAIL single.handler_pc got %0h want 1020", bus.handler_pc); else passCount++;
        checkCount++; if (bus.uepc !== 32'h200) $display("[TB] FAIL single.uepc got %0h want 200", bus.uepc); else passCount++;
        checkCount++; if (bus.ack !== 6'b000100) $display("[TB] FAIL single.ack got %0h want 04", bus.ack); else passCount++;
        checkCount++; if (bus.in_service !== 1'b1) $display("[TB] FAIL single.in_service got %0h want 1", bus.in_service); else passCount++;
        applyStimulus(6'b000100, 1'b1, 1'b1, 32'h1024, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b0 || bus.ack !== 6'h00) $display("[TB] FAIL single.pulse_width got take=%0h ack=%0h want 0/0", bus.intr_take, bus.ack); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1028, 1'b1);
        checkCount++; if (bus.in_service !== 1'b0) $display("[TB] FAIL single.uret got %0h want 0", bus.in_service); else passCount++;
    endtask

    task automatic test_simultaneous();
        applyStimulus(6'b010010, 1'b1, 1'b1, 32'h300, 1'b0);
        applyStimulus(6'b010010, 1'b1, 1'b1, 32'h300, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1 || bus.handler_pc !== 32'h1010) $display("[TB] FAIL simul.first got take=%0h pc=%0h want 1/1010", bus.intr_take, bus.handler_pc); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1014, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1018, 1'b1);
        checkCount++; if (bus.in_service !== 1'b0 || bus.intr_take !== 1'b0) $display("[TB] FAIL simul.gap got svc=%0h take=%0h want 0/0", bus.in_service, bus.intr_take); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h304, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1 || bus.handler_pc !== 32'h1040) $display("[TB] FAIL simul.second got take=%0h pc=%0h want 1/1040", bus.intr_take, bus.handler_pc); else passCount++;
        checkCount++; if (bus.ack !== 6'b010000 || bus.uepc !== 32'h304) $display("[TB] FAIL simul.second_ctx got ack=%0h uepc=%0h want 10/304", bus.ack, bus.uepc); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1044, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1048, 1'b1);
    endtask

    task automatic test_held_level();
        int takes = 0;
        int acks  = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(6'b000001, 1'b1, 1'b1, 32'h400 + 32'(4 * i), (i == 5));
            if (bus.intr_take === 1'b1) takes++;
            if (bus.ack[0] === 1'b1) acks++;
        end
        checkCount++; if (takes != 1) $display("[TB] FAIL held.takes got %0d want 1", takes); else passCount++;
        checkCount++; if (acks != 1) $display("[TB] FAIL held.acks got %0d want 1", acks); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h440, 1'b0);
        applyStimulus(6'b000001, 1'b1, 1'b1, 32'h444, 1'b0);
        applyStimulus(6'b000001, 1'b1, 1'b1, 32'h448, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1 || bus.cause !== 3'd0) $display("[TB] FAIL held.retake got take=%0h cause=%0h want 1/0", bus.intr_take, bus.cause); else passCount++;
        applyStimulus(6'b000001, 1'b1, 1'b1, 32'h1004, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1008, 1'b1);
    endtask

    task automatic test_gating();
        int takes = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(6'b001000, 1'b0, i[0], 32'h500, 1'b0);
            if (bus.intr_take === 1'b1) takes++;
        end
        checkCount++; if (takes != 0) $display("[TB] FAIL gate.ie_off got %0d takes want 0", takes); else passCount++;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(6'b001000, 1'b1, 1'b0, 32'h500, 1'b0);
            if (bus.intr_take === 1'b1) takes++;
        end
        checkCount++; if (takes != 0) $display("[TB] FAIL gate.no_boundary got %0d takes want 0", takes); else passCount++;
        applyStimulus(6'b001000, 1'b1, 1'b1, 32'h508, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1 || bus.cause !== 3'd3 || bus.uepc !== 32'h508) $display("[TB] FAIL gate.take got take=%0h cause=%0h uepc=%0h want 1/3/508", bus.intr_take, bus.cause, bus.uepc); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1034, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1038, 1'b1);
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h50c, 1'b1);
        checkCount++; if (bus.in_service !== 1'b0 || bus.intr_take !== 1'b0) $display("[TB] FAIL gate.idle_uret got svc=%0h take=%0h want 0/0", bus.in_service, bus.intr_take); else passCount++;
    endtask

    task automatic test_reset_mid_handler();
        int takes = 0;
        applyStimulus(6'b100000, 1'b1, 1'b1, 32'h340, 1'b0);
        applyStimulus(6'b100000, 1'b1, 1'b1, 32'h344, 1'b0);
        applyStimulus(6'b100100, 1'b1, 1'b1, 32'h1054, 1'b0);
        checkCount++; if (bus.in_service !== 1'b1 || bus.uepc !== 32'h344) $display("[TB] FAIL rstmid.pre got svc=%0h uepc=%0h want 1/344", bus.in_service, bus.uepc); else passCount++;
        RST = 1'b1;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h0, 1'b0);
        RST = 1'b0;
        checkCount++; if (bus.in_service !== 1'b0 || bus.uepc !== 32'h0) $display("[TB] FAIL rstmid.post got svc=%0h uepc=%0h want 0/0", bus.in_service, bus.uepc); else passCount++;
        checkCount++; if (bus.handler_pc !== 32'h1000 || bus.cause !== 3'd0) $display("[TB] FAIL rstmid.vector got pc=%0h cause=%0h want 1000/0", bus.handler_pc, bus.cause); else passCount++;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(6'b000000, 1'b1, 1'b1, 32'h600, 1'b0);
            if (bus.intr_take === 1'b1) takes++;
        end
        checkCount++; if (takes != 0) $display("[TB] FAIL rstmid.pend_cleared got %0d takes want 0", takes); else passCount++;
        applyStimulus(6'b000100, 1'b1, 1'b1, 32'h604, 1'b0);
        applyStimulus(6'b000100, 1'b1, 1'b1, 32'h608, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1 || bus.cause !== 3'd2) $display("[TB] FAIL rstmid.new_edge got take=%0h cause=%0h want 1/2", bus.intr_take, bus.cause); else passCount++;
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1024, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b1, 32'h1028, 1'b1);
    endtask

`ifdef NESTED_INTR_EN
    task automatic test_nested();
        applyStimulus(6'b001000, 1'b1, 1'b1, 32'h700, 1'b0);
        applyStimulus(6'b001000, 1'b1, 1'b1, 32'h700, 1'b0);
        applyStimulus(6'b001000, 1'b1, 1'b1, 32'h1030, 1'b0);
        applyStimulus(6'b001001, 1'b0, 1'b1, 32'h1034, 1'b0);
        applyStimulus(6'b001001, 1'b0, 1'b1, 32'h1038, 1'b0);
        checkCount++; if (bus.intr_take !== 1'b1 || bus.cause !== 3'd0 || bus.uepc !== 32'h1038) $display("[TB] FAIL nest.preempt got take=%0h cause=%0h uepc=%0h want 1/0/1038", bus.intr_take, bus.cause, bus.uepc); else passCount++;
        applyStimulus(6'b001001, 1'b0, 1'b1, 32'h1004, 1'b0);
        applyStimulus(6'b000000, 1'b0, 1'b1, 32'h1008, 1'b1);
        checkCount++; if (bus.cause !== 3'd3 || bus.uepc !== 32'h700 || bus.in_service !== 1'b1) $display("[TB] FAIL nest.pop got cause=%0h uepc=%0h svc=%0h want 3/700/1", bus.cause, bus.uepc, bus.in_service); else passCount++;
        applyStimulus(6'b000000, 1'b0, 1'b1, 32'h103c, 1'b1);
        checkCount++; if (bus.in_service !== 1'b0) $display("[TB] FAIL nest.final_uret got %0h want 0", bus.in_service); else passCount++;
    endtask
`endif

    task automatic test_random();
        logic [NS-1:0] irq = '0;
        logic [74:0]   got, want;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(7) == 0) irq[b] = ~irq[b];
            end
            applyStimulus(irq, ($urandom_range(3) != 0), 1'($urandom_range(1)),
                          $urandom & 32'hffff_fffc, ($urandom_range(3) == 0));
            got  = {bus.intr_take, bus.ack, bus.in_service, bus.cause, bus.handler_pc, bus.uepc};
            want = {mTake, (mTake ? NS'(1 << mCause) : NS'(0)), (mTake | mServing), 3'(mCause),
                    32'h1000 + 32'(mCause) * 32'd16, mEpc};
            checkCount++;
            if (got !== want) $display("[TB] FAIL random.cycle%0d got %h want %h", c, got, want);
            else passCount++;
        end
    endtask

    initial begin
        bus.irq_in     = '0;
        bus.ie         = 1'b0;
        bus.instr_done = 1'b0;
        bus.pc_next    = '0;
        bus.uret       = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_simultaneous();
        test_held_level();
        test_gating();
        test_reset_mid_handler();
`ifdef NESTED_INTR_EN
        test_nested();
`endif
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/intr_resp_ctrl.md
Name: intr_resp_ctrl

Overview:
CPU-side responder for the multi-source interrupt request lines.
- Captures per-source requests and selects the highest-priority pending one.
- Takes the selected request only at an instruction boundary: saves the return PC into uepc, redirects fetch to a fixed handler vector and acknowledges the source.
- Restores the non-serving state on uret.
- Sits between the peripheral request lines and the PC/next-PC mux of the single-cycle/pipelined RISC-V core.

Parameters:
NSRC, 6, number of request sources; bit 0 = INTR1 (highest priority)
PC_W, 32, PC/address width
VEC_BASE, 32'h0000_1000, handler address of source 0
VEC_SHIFT, 4, log2 of byte spacing between handler entries

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  reset; synchronous, active-high
irq_in  in  NSRC  raw request lines, level, asynchronous to instruction flow but synchronous to CLK
ie  in  1  global interrupt enable (UIE)
instr_done  in  1  an instruction retires at this edge (legal boundary)
pc_next  in  PC_W  address of the next sequential instruction at the retiring edge
uret  in  1  retiring instruction is uret; qualified by instr_done
intr_take  out  1  one-cycle pulse: fetch must load handler_pc
handler_pc  out  PC_W  VEC_BASE + (cause << VEC_SHIFT)
uepc  out  PC_W  saved return address
ack  out  NSRC  one-cycle one-hot clear pulse to the serviced source
in_service  out  1  a handler is executing
cause  out  3  index of the source being serviced

Behaviour:
- Reset: all of the following are 0: pend, irq_d, intr_take, ack, uepc, cause, in_service. handler_pc = VEC_BASE. State = IDLE. Reset mid-handler discards the saved context.
- Capture: irq_d <= irq_in. pend[i] is set on a rising edge of irq_in[i]; a held level does not re-fire. pend[i] is cleared in the cycle ack[i] is high. If set and clear coincide, set wins.
- Select: sel = lowest index i with pend[i]=1 (combinational priority encoder). any = |pend.
- States:
  - IDLE -> TAKE when ie & any & instr_done at edge k. In that transition: uepc <= pc_next; cause <= sel.
  - TAKE, one cycle (k+1): intr_take=1; ack[cause]=1; in_service=1; handler_pc valid. Then -> SERVE.
  - SERVE -> IDLE when instr_done & uret at edge m. in_service=0 from cycle m+1.
  - In SERVE: requests keep accumulating in pend. The earliest next take is at the first instr_done edge after m, so at least one instruction at uepc executes.
- uret seen while in IDLE: ignored; no state change.
- ie=0: requests stay pending and are taken when ie returns to 1.
- Latency:
  - Request edge to pend set: 1 cycle.
  - Boundary to intr_take: 1 cycle.
  - Total latency from irq_in rising to intr_take: 2 cycles plus the wait for the next instr_done.
- Widths: handler_pc arithmetic is modulo 2^PC_W. cause is zero-extended before the shift.

Optional Feature:
NESTED_INTR_EN.
- Defined:
  - In SERVE, a pending source with index < cause is taken at the next instr_done, even if ie=0 is not asserted by the handler.
  - Current {cause, uepc} is pushed onto an internal stack of depth NSRC.
  - uret pops the stack and restores cause/uepc; the state stays SERVE while the stack is non-empty.
  - in_service drops only when a uret occurs with the stack empty.
  - Equal or lower priority requests wait.
- Not defined: no preemption and no stack; the single uepc/cause register pair is used as described above.

Decomposition:
- Package intr_pkg holds:
  - state enum IDLE/TAKE/SERVE
  - NSRC_DEF, PC_W_DEF, VEC_BASE_DEF, VEC_SHIFT_DEF
  - ctx_t struct {cause[2:0], epc[PC_W-1:0]}
- One natural sub-module: intr_prio_enc (NSRC-bit lowest-index-first priority encoder, outputs sel and any). It is reused by the nesting comparison.

Test Plan:
- Single request: pulse irq_in[2] 0->1, ie=1, instr_done every cycle, pc_next=0x200 -> intr_take one cycle, cause=2, handler_pc=0x1020, uepc=0x200, ack=6'b000100, in_service=1.
- Simultaneous: irq_in[4] and irq_in[1] rise in the same cycle -> source 1 is taken first (handler 0x1010). After uret, source 4 is taken at the next boundary (handler 0x1040). pend[4] survives the first handler.
- Held level: irq_in[0] held high across the handler and uret -> exactly one take and one ack. No second intr_take until irq_in[0] falls and rises again.
- Gating: ie=0 with pending source 3 and instr_done pulsing -> no take. Raise ie -> take at the next instr_done. Also: instr_done held 0 delays the take indefinitely.
- Reset mid-handler: assert RST in SERVE with uepc=0x344 -> next cycle in_service=0, uepc=0, pend=0. No take occurs after RST is released until a new rising edge on a request line.
- NESTED_INTR_EN: serving source 3, source 0 rises -> preempt, uepc=handler-3 pc_next. First uret restores cause=3 and its uepc with in_service still 1. Second uret drops in_service.
